// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with leading-zero blanking,
// PWM dimming and frame-synchronous (tear-free) display updates.
module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BRIGHT_BITS   = 4
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   enable_mask,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [7:0]              Cathodes,
  output logic [2:0]              digit_idx,
  output logic                    scan_wrap
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [2:0]               r_idx;
  logic [4*NUM_DIGITS-1:0]  r_pend_digits;
  logic [4*NUM_DIGITS-1:0]  r_com_digits;
  logic [NUM_DIGITS-1:0]    r_pend_dp;
  logic [NUM_DIGITS-1:0]    r_com_dp;
  logic                     r_pend_valid;
  logic [NUM_DIGITS-1:0]    r_an;
  logic [7:0]               r_cath;
  logic [2:0]               r_digit_idx;
  logic                     r_scan_wrap;

  logic                     w_slot_end;
  logic                     w_frame_wrap;
  logic [BRIGHT_BITS-1:0]   w_pwm;
  logic [NUM_DIGITS-1:0]    w_suppress;
  logic [3:0]               w_nibble;
  logic                     w_dp;
  logic                     w_enable;
  logic                     w_sup_cur;
  logic                     w_visible;
  logic [NUM_DIGITS-1:0]    w_an_next;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  assign w_slot_end   = &r_presc;
  assign w_frame_wrap = w_slot_end && (r_idx == LAST_IDX);
  assign w_pwm        = r_presc[SCAN_DIV_BITS-1 -: BRIGHT_BITS];

  // Suppression runs from the most significant digit down and stops at the
  // first digit with a non-zero nibble or a lit dp; digit 0 always shows.
  always_comb begin
    logic w_lz_run;
    w_suppress = '0;
    w_lz_run   = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_run      = w_lz_run && (r_com_digits[4*i +: 4] == 4'd0) && !r_com_dp[i];
      w_suppress[i] = w_lz_run;
    end
  end

  always_comb begin
    w_nibble  = 4'd0;
    w_dp      = 1'b0;
    w_enable  = 1'b0;
    w_sup_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_nibble  = r_com_digits[4*i +: 4];
        w_dp      = r_com_dp[i];
        w_enable  = enable_mask[i];
        w_sup_cur = w_suppress[i];
      end
    end
  end

  // The first cycle of every slot is forced dark to avoid ghosting on idx change.
  assign w_visible = w_enable && !w_sup_cur && (w_pwm < brightness) && (r_presc != '0);

  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_next[i] = !(w_visible && (r_idx == 3'(i)));
    end
  end

  // load is an always-accepted one-cycle strobe (no ready): the last load
  // before a frame wrap wins, and a load on the wrap cycle commits directly.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_presc       <= '0;
      r_idx         <= 3'd0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_com_digits  <= '0;
      r_com_dp      <= '0;
      r_an          <= '1;
      r_cath        <= 8'hFF;
      r_digit_idx   <= 3'd0;
      r_scan_wrap   <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_frame_wrap) begin
        if (load) begin
          r_com_digits <= digits_in;
          r_com_dp     <= dp_in;
        end else if (r_pend_valid) begin
          r_com_digits <= r_pend_digits;
          r_com_dp     <= r_pend_dp;
        end
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_digits <= digits_in;
        r_pend_dp     <= dp_in;
        r_pend_valid  <= 1'b1;
      end
      r_an        <= w_an_next;
      r_cath      <= w_visible ? {seg7(w_nibble), ~w_dp} : 8'hFF;
      r_digit_idx <= r_idx;
      r_scan_wrap <= w_frame_wrap;
    end
  end

  assign An        = r_an;
  assign Cathodes  = r_cath;
  assign digit_idx = r_digit_idx;
  assign scan_wrap = r_scan_wrap;

endmodule
